// File: rtl/rotate_mask_pipe_if.sv
// Issue/result bundle for the rotate-and-mask pipeline.
// Buses use big-endian numbering: word slot 0 is the most significant 32 bits.
interface rotate_mask_pipe_if #(
    parameter int unsigned WIDTH = 128
);
    logic              issue_valid;
    logic [31:0]       instruction;
    logic [WIDTH-1:0]  RA_data_in;
    logic [WIDTH-1:0]  RB_data_in;
    logic              flush;
    logic              result_valid;
    logic              rt_write_en;
    logic [6:0]        rt_addr_out;
    logic [WIDTH-1:0]  RT_data_out;

    modport master (
        output issue_valid, instruction, RA_data_in, RB_data_in, flush,
        input  result_valid, rt_write_en, rt_addr_out, RT_data_out
    );

    modport slave (
        input  issue_valid, instruction, RA_data_in, RB_data_in, flush,
        output result_valid, rt_write_en, rt_addr_out, RT_data_out
    );
endinterface

// File: rtl/rotate_mask_pipe.sv
// Three-stage rotate-and-mask (logical/arithmetic right shift by negated count) unit.
// Fixed latency of three cycles, one issue per cycle, flushable, no backpressure.
module rotate_mask_pipe #(
    parameter int unsigned WIDTH = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    rotate_mask_pipe_if.slave bus
);
    localparam int unsigned LATENCY = 3;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SLOTS   = WIDTH / WORD_W;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned OPC_W   = 11;
    localparam int unsigned ADDR_W  = 7;

    localparam logic [OPC_W-1:0] OPC_ROTM   = 11'b00001011001;
    localparam logic [OPC_W-1:0] OPC_ROTMI  = 11'b00001111001;
    localparam logic [OPC_W-1:0] OPC_ROTMA  = 11'b00001011010;
    localparam logic [OPC_W-1:0] OPC_ROTMAI = 11'b00001111010;

    typedef logic [SLOTS-1:0][WORD_W-1:0] words_t;
    typedef logic [SLOTS-1:0][CNT_W-1:0]  counts_t;

    // Shift right by cnt; counts of 32 or more leave only the fill pattern.
    function automatic logic [WORD_W-1:0] shift_word(
        input logic [WORD_W-1:0] w,
        input logic [CNT_W-1:0]  cnt,
        input logic              arith
    );
        logic [WORD_W-1:0] fill;
        logic [WORD_W-1:0] keep;
        fill = {WORD_W{arith & w[WORD_W-1]}};
        keep = {WORD_W{1'b1}} >> cnt[CNT_W-2:0];
        if (cnt[CNT_W-1]) begin
            return fill;
        end
        return (w >> cnt[CNT_W-2:0]) | (fill & ~keep);
    endfunction

    logic [OPC_W-1:0]  opcode;
    logic [WORD_W-1:0] imm;
    logic              known_c;
    logic              arith_c;
    logic              imm_form_c;
    words_t            ra_words;
    words_t            rb_words;
    counts_t           cnt_c;
    words_t            shifted_c;
    logic              unused_instr_bits;

    // Big-endian fields: opcode = bits 0..10, I7 = 11..17, RT = 25..31.
    assign opcode            = bus.instruction[31:21];
    assign imm               = 32'($signed(bus.instruction[20:14]));
    assign unused_instr_bits = ^bus.instruction[13:7];
    assign ra_words          = bus.RA_data_in;
    assign rb_words          = bus.RB_data_in;

    always_comb begin
        known_c    = 1'b0;
        arith_c    = 1'b0;
        imm_form_c = 1'b0;
        case (opcode)
            OPC_ROTM:   begin known_c = 1'b1; end
            OPC_ROTMI:  begin known_c = 1'b1; imm_form_c = 1'b1; end
            OPC_ROTMA:  begin known_c = 1'b1; arith_c = 1'b1; end
            OPC_ROTMAI: begin known_c = 1'b1; arith_c = 1'b1; imm_form_c = 1'b1; end
            default:    begin known_c = 1'b0; end
        endcase
    end

    // Slot mapping is positional, so per-index work preserves slot order.
    always_comb begin
        cnt_c = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            cnt_c[k] = CNT_W'(32'd0 - (imm_form_c ? imm : rb_words[k]));
        end
    end

    // vld[0] = S1, vld[1] = S2, vld[LATENCY-1] = result stage.
    logic [LATENCY-1:0] vld;
    logic               s1_known;
    logic               s1_arith;
    counts_t            s1_cnt;
    words_t             s1_ra;
    logic [ADDR_W-1:0]  s1_addr;
    logic               s2_known;
    words_t             s2_data;
    logic [ADDR_W-1:0]  s2_addr;
    logic               wen_q;
    words_t             data_q;
    logic [ADDR_W-1:0]  addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
        end else if (bus.flush) begin
            vld <= '0;
        end else begin
            vld <= {vld[LATENCY-2:0], bus.issue_valid};
        end
    end

    // S1: decode, counts, operand and target capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_known <= 1'b0;
            s1_arith <= 1'b0;
            s1_cnt   <= '0;
            s1_ra    <= '0;
            s1_addr  <= '0;
        end else if (bus.issue_valid) begin
            s1_known <= known_c;
            s1_arith <= arith_c;
            s1_cnt   <= cnt_c;
            s1_ra    <= ra_words;
            s1_addr  <= bus.instruction[ADDR_W-1:0];
        end
    end

    always_comb begin
        shifted_c = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            shifted_c[k] = shift_word(s1_ra[k], s1_cnt[k], s1_arith);
        end
    end

    // S2: shifted words; unknown opcodes carry zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_known <= 1'b0;
            s2_data  <= '0;
            s2_addr  <= '0;
        end else if (vld[0]) begin
            s2_known <= s1_known;
            s2_data  <= s1_known ? shifted_c : '0;
            s2_addr  <= s1_addr;
        end
    end

    // Result stage: data and address hold whenever no valid result arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wen_q  <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            wen_q <= vld[1] & s2_known & ~bus.flush;
            if (vld[1] && !bus.flush) begin
                data_q <= s2_data;
                addr_q <= s2_addr;
            end
        end
    end

    assign bus.result_valid = vld[LATENCY-1];
    assign bus.rt_write_en  = wen_q;
    assign bus.RT_data_out  = data_q;
    assign bus.rt_addr_out  = addr_q;
endmodule

// File: tb/tb_rotate_mask_pipe.sv
// Directed bench for rotate_mask_pipe: latency, shift math, bubbles, flush and reset.
module tb_rotate_mask_pipe;
    localparam int unsigned WIDTH = 128;

    localparam logic [10:0] OP_ROTM   = 11'b00001011001;
    localparam logic [10:0] OP_ROTMI  = 11'b00001111001;
    localparam logic [10:0] OP_ROTMA  = 11'b00001011010;
    localparam logic [10:0] OP_ROTMAI = 11'b00001111010;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rotate_mask_pipe_if #(.WIDTH(WIDTH)) bus_i ();

    rotate_mask_pipe #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_i.slave)
    );

    function automatic logic [31:0] mk(input logic [10:0] op, input logic [6:0] i7,
                                       input logic [6:0] rt);
        return {op, i7, 7'b0, rt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [WIDTH-1:0] ra,
                         input logic [WIDTH-1:0] rb, input logic fl);
        bus_i.issue_valid = 1'b1;
        bus_i.instruction = ins;
        bus_i.RA_data_in  = ra;
        bus_i.RB_data_in  = rb;
        bus_i.flush       = fl;
    endtask

    // Bubble with junk operands, which must not matter.
    task automatic idle(input logic fl);
        bus_i.issue_valid = 1'b0;
        bus_i.instruction = $urandom;
        bus_i.RA_data_in  = {$urandom, $urandom, $urandom, $urandom};
        bus_i.RB_data_in  = {$urandom, $urandom, $urandom, $urandom};
        bus_i.flush       = fl;
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic we,
                           input logic [6:0] rt, input logic [WIDTH-1:0] data);
        chk({tag, ".valid"}, WIDTH'(bus_i.result_valid), WIDTH'(rv));
        chk({tag, ".wen"},   WIDTH'(bus_i.rt_write_en),  WIDTH'(we));
        chk({tag, ".addr"},  WIDTH'(bus_i.rt_addr_out),  WIDTH'(rt));
        chk({tag, ".data"},  bus_i.RT_data_out,          data);
    endtask

    initial begin
        reset_n = 1'b0;
        idle(1'b0);
        #2;
        chk_out("reset", 1'b0, 1'b0, 7'd0, '0);
        tick();
        tick();
        reset_n = 1'b1;

        // Unknown opcode: valid result, no write, zero data, address carried.
        issue(mk(11'b0, 7'h7C, 7'd9), {4{32'hFFFFFFFF}}, '0, 1'b0);
        tick();
        idle(1'b0);
        tick();
        tick();
        chk_out("unknown", 1'b1, 1'b0, 7'd9, '0);

        // rotmi -4 with exact-latency check.
        issue(mk(OP_ROTMI, 7'h7C, 7'd5), {4{32'h80000001}}, '0, 1'b0);
        tick();
        idle(1'b0);
        tick();
        chk("rotmi.n2_valid", WIDTH'(bus_i.result_valid), WIDTH'(1'b0));
        tick();
        chk_out("rotmi", 1'b1, 1'b1, 7'd5, {4{32'h08000000}});

        // Three back-to-back issues emerge back-to-back in order.
        issue(mk(OP_ROTMAI, 7'h7C, 7'd6), {4{32'h80000000}}, '0, 1'b0);
        tick();
        issue(mk(OP_ROTMAI, 7'h40, 7'd7), {4{32'h80000000}}, '0, 1'b0);
        tick();
        issue(mk(OP_ROTM, 7'h00, 7'd8), {4{32'hFFFFFFFF}},
              {32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFE1, 32'hFFFFFFE0}, 1'b0);
        tick();
        idle(1'b0);
        chk_out("rotmai_m4", 1'b1, 1'b1, 7'd6, {4{32'hF8000000}});
        tick();
        chk_out("rotmai_c0", 1'b1, 1'b1, 7'd7, {4{32'h80000000}});
        tick();
        chk_out("rotm_rr", 1'b1, 1'b1, 7'd8,
                {32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h00000000});
        tick();
        chk_out("bubble_hold", 1'b0, 1'b0, 7'd8,
                {32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h00000000});

        // rotma register form: counts 1, 4, 32, 40.
        issue(mk(OP_ROTMA, 7'h00, 7'd10),
              {32'h80000000, 32'h7FFFFFF0, 32'h80000001, 32'h12345678},
              {32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFE0, 32'hFFFFFFD8}, 1'b0);
        tick();
        idle(1'b0);
        tick();
        tick();
        chk_out("rotma_rr", 1'b1, 1'b1, 7'd10,
                {32'hC0000000, 32'h07FFFFFF, 32'hFFFFFFFF, 32'h00000000});

        // Four issues, flush held over the third and fourth issue cycles.
        tick();
        issue(mk(OP_ROTMI, 7'h7C, 7'd20), {4{32'h11111111}}, '0, 1'b0);
        tick();
        issue(mk(OP_ROTMI, 7'h7C, 7'd21), {4{32'h22222222}}, '0, 1'b0);
        tick();
        issue(mk(OP_ROTMI, 7'h7C, 7'd22), {4{32'h33333333}}, '0, 1'b1);
        tick();
        issue(mk(OP_ROTMI, 7'h7C, 7'd23), {4{32'h44444444}}, '0, 1'b1);
        chk("flush.after_valid", WIDTH'(bus_i.result_valid), WIDTH'(1'b0));
        tick();
        idle(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("flush.valid", WIDTH'(bus_i.result_valid), WIDTH'(1'b0));
            tick();
        end
        chk_out("flush_hold", 1'b0, 1'b0, 7'd10,
                {32'hC0000000, 32'h07FFFFFF, 32'hFFFFFFFF, 32'h00000000});

        // Normal operation after flush; rotmi -16 checks slot ordering.
        issue(mk(OP_ROTMI, 7'h70, 7'd11),
              {32'hDEADBEEF, 32'h12345678, 32'hFFFF0000, 32'h0000FFFF}, '0, 1'b0);
        tick();
        idle(1'b0);
        tick();
        tick();
        chk_out("post_flush", 1'b1, 1'b1, 7'd11,
                {32'h0000DEAD, 32'h00001234, 32'h0000FFFF, 32'h00000000});

        // Reset with operations in flight clears outputs asynchronously.
        tick();
        issue(mk(OP_ROTMI, 7'h7C, 7'd30), {4{32'h55555555}}, '0, 1'b0);
        tick();
        issue(mk(OP_ROTMI, 7'h7C, 7'd31), {4{32'h66666666}}, '0, 1'b0);
        tick();
        issue(mk(OP_ROTMI, 7'h7C, 7'd32), {4{32'h77777777}}, '0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b0, 7'd0, '0);
        idle(1'b0);
        tick();
        #2;
        reset_n = 1'b1;

        // First edge after release accepts an issue; old ops never appear.
        issue(mk(OP_ROTMAI, 7'h7F, 7'd12), {4{32'hF0000001}}, '0, 1'b0);
        tick();
        idle(1'b0);
        chk("post_reset.n1_valid", WIDTH'(bus_i.result_valid), WIDTH'(1'b0));
        tick();
        chk("post_reset.n2_valid", WIDTH'(bus_i.result_valid), WIDTH'(1'b0));
        tick();
        chk_out("post_reset", 1'b1, 1'b1, 7'd12, {4{32'hF8000000}});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset.idle_valid", WIDTH'(bus_i.result_valid), WIDTH'(1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rotate_mask_pipe.md
ROTATE_MASK_PIPE -- requirements
Module: rotate_mask_pipe

Interface
REQ-001 Parameter: WIDTH, 128, register/operand width in bits (4 word slots of 32).
REQ-002 Parameter: LATENCY, 3, fixed issue-to-result latency in cycles; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 issue_valid  input  1  instruction and operands valid this cycle.
REQ-006 instruction  input  32  instruction word, bit 0 = MSB.
REQ-007 RA_data_in  input  WIDTH  operand RA, bit 0 = MSB.
REQ-008 RB_data_in  input  WIDTH  operand RB (per-word shift counts for RR forms).
REQ-009 flush  input  1  kill all in-flight operations.
REQ-010 result_valid  output  1  result present on result outputs this cycle.
REQ-011 rt_write_en  output  1  result is to be written to register file.
REQ-012 rt_addr_out  output  7  target register (instruction[25:31]) carried with result.
REQ-013 RT_data_out  output  WIDTH  result data.

Function
REQ-014 Word slot j (0..3) SHALL occupy bits [32j : 32j+31] of every WIDTH bus.
REQ-015 Decoded ops (instruction[0:10]): 00001011001 rotm; 00001111001 rotmi; 00001011010 rotma; 00001111010 rotmai.
REQ-016 Immediate I7 = instruction[11:17], sign-extended to 32 bits; RR forms use RB word j.
REQ-017 Per slot: count = (0 - src) & 0x3F, src = I7 (immediate forms) or RB word j (RR forms).
REQ-018 rotm/rotmi: count < 32 -> result bit b = RA bit b-count for b >= count, 0 for b < count; count >= 32 -> word = 0.
REQ-019 rotma/rotmai: same as REQ-018 but vacated bits = RA word bit 0 (sign); count >= 32 -> word = 32 copies of sign.
REQ-020 count = 0 SHALL return RA word unchanged.
REQ-021 Fully pipelined, 3 stages: S1 registers decode, counts, RA, rt_addr; S2 registers per-slot shifted words; S3 registers outputs.
REQ-022 issue_valid high in cycle N SHALL produce result_valid high in cycle N+3 with its result; one issue accepted every cycle, no backpressure.
REQ-023 Back-to-back issues SHALL emerge back-to-back in issue order, no bubbles inserted.
REQ-024 Unrecognised opcode with issue_valid: result_valid = 1, rt_write_en = 0, RT_data_out = 0, rt_addr_out carried.
REQ-025 Recognised opcode: rt_write_en = result_valid.
REQ-026 issue_valid low: that slot travels as bubble; result_valid = 0, rt_write_en = 0 in cycle N+3.
REQ-027 When result_valid = 0, RT_data_out and rt_addr_out SHALL hold their previous values.
REQ-028 flush high at a rising edge SHALL clear valid bits of S1, S2, S3; an issue presented in the same cycle as flush SHALL be discarded.
REQ-029 Flush SHALL not alter RT_data_out/rt_addr_out; result_valid = 0 the cycle after flush.
REQ-030 Operands need not be held after the issue cycle.

Reset
REQ-031 reset_n low SHALL immediately (asynchronously) force result_valid = 0, rt_write_en = 0, RT_data_out = 0, rt_addr_out = 0, all stage valids = 0.
REQ-032 Assertion mid-operation SHALL discard all in-flight operations; none emerge after release.
REQ-033 First issue accepted on the first rising edge with reset_n high; its result at +3 cycles.

Verification
REQ-034 rotmi, I7 = 7'h7C (-4), RA words = 32'h80000001 -> N+3: all words 32'h08000000, rt_write_en = 1.
REQ-035 rotmai, I7 = -4, RA word = 32'h80000000 -> 32'hF8000000; I7 = 7'h40 (-64, count 0) -> 32'h80000000 unchanged.
REQ-036 rotm, RB words = {0, -1, -31, -32}, RA all 32'hFFFFFFFF -> {FFFFFFFF, 7FFFFFFF, 00000001, 00000000}.
REQ-037 Issue 4 consecutive ops then flush in cycle N+2 -> no result_valid for any of them; later issue completes normally.
REQ-038 Unknown opcode 11'b0 with issue_valid -> result_valid = 1, rt_write_en = 0, data 0 at N+3.
REQ-039 Assert reset_n low with 3 ops in flight, release -> outputs 0 immediately, no result_valid for the 3 ops.
